// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, requester ids,
// lsu_op encodings and access-size helpers.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } arb_state_e;

   typedef enum logic {
      REQ_IFU = 1'b0,
      REQ_LSU = 1'b1
   } req_id_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LW  = 3'b010;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;

   // Unlisted encodings (011/110/111) fall through to word size.
   function automatic size_e op_size(input logic [2:0] op);
      case (op)
         OP_LB, OP_LBU: op_size = SZ_BYTE;
         OP_LH, OP_LHU: op_size = SZ_HALF;
         default:       op_size = SZ_WORD;
      endcase
   endfunction

   function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
      case (op_size(op))
         SZ_BYTE: op_misaligned = 1'b0;
         SZ_HALF: op_misaligned = off[0];
         default: op_misaligned = (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store data shift + byte mask on the request side,
// load data shift + sign/zero extension on the response side. Pure comb.
module mem_lane_align
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        st_op_i,
   input  logic [1:0]        st_off_i,
   input  logic [DATA_W-1:0] st_wdata_i,
   output logic [3:0]        st_wmask_o,
   output logic [DATA_W-1:0] st_wdata_o,
   input  logic [2:0]        ld_op_i,
   input  logic [1:0]        ld_off_i,
   input  logic [DATA_W-1:0] ld_word_i,
   output logic [DATA_W-1:0] ld_data_o
);

   logic [DATA_W-1:0] ld_sh;
   logic              ld_sgn;

   // Store side: place low-lane data at its byte offset and build the mask
   always_comb begin
      st_wdata_o = st_wdata_i << {st_off_i, 3'b000};
      case (op_size(st_op_i))
         SZ_BYTE: st_wmask_o = 4'b0001 << st_off_i;
         SZ_HALF: st_wmask_o = 4'b0011 << st_off_i;
         default: st_wmask_o = 4'b1111;
      endcase
   end

   // Load side: bring addressed bytes down to lane 0, then extend
   always_comb begin
      ld_sh  = ld_word_i >> {ld_off_i, 3'b000};
      ld_sgn = ~ld_op_i[2];
      case (op_size(ld_op_i))
         SZ_BYTE: ld_data_o = {{(DATA_W-8){ld_sgn & ld_sh[7]}}, ld_sh[7:0]};
         SZ_HALF: ld_data_o = {{(DATA_W-16){ld_sgn & ld_sh[15]}}, ld_sh[15:0]};
         default: ld_data_o = ld_sh;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (IFU/LSU) arbiter onto a single-outstanding memory port.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration;
// otherwise the LSU has fixed priority. Only DATA_W = 32 is supported.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_we,
   input  logic [2:0]        lsu_op,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e        state_q, state_d;
   req_id_e           owner_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        wmask_q;
   logic [DATA_W-1:0] rword_q;
   logic              err_q;

   logic              gnt_lsu;
   logic              accept;
   logic              lsu_misal;
   logic [3:0]        st_wmask;
   logic [DATA_W-1:0] st_wdata;
   logic [DATA_W-1:0] ld_data;

`ifdef MEM_ARB_RR_EN
   req_id_e           ptr_q;

   // Remember who won last so contention alternates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ptr_q <= REQ_IFU;
      else if (accept) ptr_q <= gnt_lsu ? REQ_LSU : REQ_IFU;
   end

   // Round-robin pick: on contention the side not granted last wins
   always_comb begin
      if (lsu_req_valid && ifu_req_valid) gnt_lsu = (ptr_q == REQ_IFU);
      else                                gnt_lsu = lsu_req_valid;
   end
`else
   // Fixed priority: LSU wins whenever it asks
   always_comb gnt_lsu = lsu_req_valid;
`endif

   assign accept        = (state_q == ST_IDLE) && (ifu_req_valid || lsu_req_valid);
   assign lsu_req_ready = (state_q == ST_IDLE) && gnt_lsu;
   assign ifu_req_ready = (state_q == ST_IDLE) && ifu_req_valid && !gnt_lsu;
   assign lsu_misal     = op_misaligned(lsu_op, lsu_addr[1:0]);

   mem_lane_align #(.DATA_W(DATA_W)) u_align (
      .st_op_i    (lsu_op),
      .st_off_i   (lsu_addr[1:0]),
      .st_wdata_i (lsu_wdata),
      .st_wmask_o (st_wmask),
      .st_wdata_o (st_wdata),
      .ld_op_i    (op_q),
      .ld_off_i   (addr_q[1:0]),
      .ld_word_i  (rword_q),
      .ld_data_o  (ld_data)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; misaligned LSU accesses bypass the memory entirely
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = (gnt_lsu && lsu_misal) ? ST_RESP : ST_REQ;
         ST_REQ:  if (mem_gnt)    state_d = ST_WAIT;
         ST_WAIT: if (mem_rvalid) state_d = ST_RESP;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: memory request and per-owner response strobes
   always_comb begin
      mem_req        = (state_q == ST_REQ);
      ifu_resp_valid = (state_q == ST_RESP) && (owner_q == REQ_IFU);
      lsu_resp_valid = (state_q == ST_RESP) && (owner_q == REQ_LSU);
   end

   // Capture the winning request; fields then stay frozen until the next accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= REQ_IFU;
         addr_q  <= '0;
         we_q    <= 1'b0;
         op_q    <= OP_LW;
         wdata_q <= '0;
         wmask_q <= 4'b0000;
         err_q   <= 1'b0;
      end else if (accept) begin
         if (gnt_lsu) begin
            owner_q <= REQ_LSU;
            addr_q  <= lsu_addr;
            we_q    <= lsu_we;
            op_q    <= lsu_op;
            wdata_q <= st_wdata;
            wmask_q <= st_wmask;
            err_q   <= lsu_misal;
         end else begin
            owner_q <= REQ_IFU;
            addr_q  <= ifu_addr;
            we_q    <= 1'b0;
            op_q    <= OP_LW;
            wdata_q <= '0;
            wmask_q <= 4'b1111;
            err_q   <= 1'b0;
         end
      end
   end

   // Read word is latched only while waiting; stray rvalid elsewhere is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                rword_q <= '0;
      else if (state_q == ST_WAIT && mem_rvalid) rword_q <= mem_rdata;
   end

   assign mem_we    = we_q;
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign ifu_rdata = rword_q;
   assign lsu_rdata = err_q ? '0 : ld_data;
   assign lsu_err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, arbitration, a vector table of
// single transactions, and a stall-then-reset sequence.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid, lsu_err;
   logic [2:0]  lsu_op;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
      .lsu_op(lsu_op), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic        lsu;
      logic        we;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] word;
      logic [31:0] e_addr;
      logic [3:0]  e_mask;
      logic [31:0] e_wdata;
      logic        chk_w;
      logic [31:0] e_rdata;
      logic        chk_rd;
      logic        e_err;
   } vec_t;

   vec_t vt [14];

   function automatic vec_t mk(logic lsu, logic we, logic [2:0] op, logic [31:0] addr,
                               logic [31:0] wdata, logic [31:0] word, logic [31:0] e_addr,
                               logic [3:0] e_mask, logic [31:0] e_wdata, logic chk_w,
                               logic [31:0] e_rdata, logic chk_rd, logic e_err);
      vec_t v;
      v.lsu = lsu; v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.word = word;
      v.e_addr = e_addr; v.e_mask = e_mask; v.e_wdata = e_wdata; v.chk_w = chk_w;
      v.e_rdata = e_rdata; v.chk_rd = chk_rd; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      if (v.lsu) begin
         lsu_req_valid = 1'b1; lsu_we = v.we; lsu_op = v.op;
         lsu_addr = v.addr; lsu_wdata = v.wdata;
      end else begin
         ifu_req_valid = 1'b1; ifu_addr = v.addr;
      end
      #1;
      chk($sformatf("v%0d_ready", idx), 32'(v.lsu ? lsu_req_ready : ifu_req_ready), 32'd1);
      tick();
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      if (!v.e_err) begin
         chk($sformatf("v%0d_mem_req", idx), 32'(mem_req), 32'd1);
         chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.e_addr);
         chk($sformatf("v%0d_mem_wmask", idx), 32'(mem_wmask), 32'(v.e_mask));
         chk($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(v.we));
         if (v.chk_w) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.e_wdata);
         mem_gnt = 1'b1;
         tick();
         mem_gnt = 1'b0;
         chk($sformatf("v%0d_req_drop", idx), 32'(mem_req), 32'd0);
         mem_rvalid = 1'b1;
         mem_rdata  = v.word;
         tick();
         mem_rvalid = 1'b0;
         mem_rdata  = 32'h0;
      end else begin
         chk($sformatf("v%0d_no_mem_req", idx), 32'(mem_req), 32'd0);
      end
      if (v.lsu) begin
         chk($sformatf("v%0d_lsu_resp", idx), 32'(lsu_resp_valid), 32'd1);
         chk($sformatf("v%0d_ifu_quiet", idx), 32'(ifu_resp_valid), 32'd0);
         chk($sformatf("v%0d_lsu_err", idx), 32'(lsu_err), 32'(v.e_err));
         if (v.chk_rd) chk($sformatf("v%0d_lsu_rdata", idx), lsu_rdata, v.e_rdata);
      end else begin
         chk($sformatf("v%0d_ifu_resp", idx), 32'(ifu_resp_valid), 32'd1);
         chk($sformatf("v%0d_lsu_quiet", idx), 32'(lsu_resp_valid), 32'd0);
         chk($sformatf("v%0d_ifu_rdata", idx), ifu_rdata, v.e_rdata);
      end
      tick();
      chk($sformatf("v%0d_pulse_end", idx), 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
   endtask

   initial begin
      logic exp_lsu [4];
      int   ng;

      //            lsu we op      addr          wdata         word          e_addr        mask     e_wdata       cw e_rdata       cr err
      vt[0]  = mk(0, 0, 3'b010, 32'h80000004, 32'h0,        32'h00000413, 32'h80000004, 4'b1111, 32'h0,        0, 32'h00000413, 1, 0);
      vt[1]  = mk(1, 0, 3'b000, 32'h80000003, 32'h0,        32'h80FF0000, 32'h80000000, 4'b1000, 32'h0,        0, 32'hFFFFFF80, 1, 0);
      vt[2]  = mk(1, 0, 3'b100, 32'h80000003, 32'h0,        32'h80FF0000, 32'h80000000, 4'b1000, 32'h0,        0, 32'h00000080, 1, 0);
      vt[3]  = mk(1, 1, 3'b001, 32'h80000002, 32'h1234ABCD, 32'h0,        32'h80000000, 4'b1100, 32'hABCD0000, 1, 32'h0,        0, 0);
      vt[4]  = mk(1, 0, 3'b001, 32'h10000002, 32'h0,        32'h80011234, 32'h10000000, 4'b1100, 32'h0,        0, 32'hFFFF8001, 1, 0);
      vt[5]  = mk(1, 0, 3'b101, 32'h10000000, 32'h0,        32'h1234F00D, 32'h10000000, 4'b0011, 32'h0,        0, 32'h0000F00D, 1, 0);
      vt[6]  = mk(1, 0, 3'b010, 32'h10000008, 32'h0,        32'hDEADBEEF, 32'h10000008, 4'b1111, 32'h0,        0, 32'hDEADBEEF, 1, 0);
      vt[7]  = mk(1, 0, 3'b111, 32'h1000000C, 32'h0,        32'h01020304, 32'h1000000C, 4'b1111, 32'h0,        0, 32'h01020304, 1, 0);
      vt[8]  = mk(1, 1, 3'b000, 32'h20000001, 32'h000000A5, 32'h0,        32'h20000000, 4'b0010, 32'h0000A500, 1, 32'h0,        0, 0);
      vt[9]  = mk(1, 1, 3'b010, 32'h20000004, 32'hCAFEF00D, 32'h0,        32'h20000004, 4'b1111, 32'hCAFEF00D, 1, 32'h0,        0, 0);
      vt[10] = mk(1, 0, 3'b010, 32'h80000001, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        0, 32'h00000000, 1, 1);
      vt[11] = mk(1, 0, 3'b101, 32'h80000003, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        0, 32'h00000000, 1, 1);
      vt[12] = mk(1, 1, 3'b110, 32'h00000003, 32'h55555555, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 32'h00000000, 1, 1);
      vt[13] = mk(1, 0, 3'b000, 32'h10000011, 32'h0,        32'h00007F00, 32'h10000010, 4'b0010, 32'h0,        0, 32'h0000007F, 1, 0);

`ifdef MEM_ARB_RR_EN
      exp_lsu[0] = 1'b1; exp_lsu[1] = 1'b0; exp_lsu[2] = 1'b1; exp_lsu[3] = 1'b0;
`else
      exp_lsu[0] = 1'b1; exp_lsu[1] = 1'b1; exp_lsu[2] = 1'b1; exp_lsu[3] = 1'b1;
`endif

      rst_n = 1'b0;
      ifu_req_valid = 1'b0; ifu_addr = 32'h0;
      lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_op = 3'b010; lsu_addr = 32'h0; lsu_wdata = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      tick();
      tick();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_resp", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
      chk("rst_lsu_err", 32'(lsu_err), 32'd0);
      chk("rst_ifu_rdata", ifu_rdata, 32'd0);
      chk("rst_lsu_rdata", lsu_rdata, 32'd0);
      rst_n = 1'b1;
      tick();

      // Contention: both sides requesting, memory always granting/completing
      ifu_req_valid = 1'b1; ifu_addr = 32'h00000100;
      lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_op = 3'b010; lsu_addr = 32'h00000040;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
      #1;
      ng = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         chk("one_ready", 32'(ifu_req_ready & lsu_req_ready), 32'd0);
         if (ifu_req_ready || lsu_req_ready) begin
            chk($sformatf("arb_grant%0d", ng), 32'(lsu_req_ready), 32'(exp_lsu[ng]));
            ng++;
         end
         tick();
      end
      chk("arb_grant_count", 32'(ng), 32'd4);
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      repeat (4) tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      tick();

      for (int i = 0; i < 14; i++) run_vec(vt[i], i);

      // Stall in REQ, then reset while in WAIT
      ifu_req_valid = 1'b1; ifu_addr = 32'h00001000;
      #1;
      chk("stall_ready", 32'(ifu_req_ready), 32'd1);
      tick();
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b1; lsu_op = 3'b010; lsu_addr = 32'h00000080;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d_req", c), 32'(mem_req), 32'd1);
         chk($sformatf("stall%0d_addr", c), mem_addr, 32'h00001000);
         chk($sformatf("stall%0d_mask", c), 32'(mem_wmask), 32'hF);
         chk($sformatf("stall%0d_we", c), 32'(mem_we), 32'd0);
         chk($sformatf("stall%0d_busy", c), 32'(lsu_req_ready), 32'd0);
         tick();
      end
      lsu_req_valid = 1'b0;
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("wait_req_low", 32'(mem_req), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_req", 32'(mem_req), 32'd0);
      chk("midrst_resp", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("post%0d_resp", c), 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
         chk($sformatf("post%0d_req", c), 32'(mem_req), 32'd0);
         chk($sformatf("post%0d_rdata", c), ifu_rdata, 32'd0);
         tick();
      end
      ifu_req_valid = 1'b1;
      #1;
      chk("post_idle_ready", 32'(ifu_req_ready), 32'd1);
      ifu_req_valid = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
